acq_capture_ctrl: RTL and testbench

//  Sequences one logic-analyser acquisition when the task dispatcher grants it.

---
 rtl/acq_capture_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_acq_capture_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_capture_ctrl.sv
// acq_capture_ctrl: sequences one logic-analyser acquisition.
// Samples the synchronised probe pins at a prescaled rate into a circular
// capture RAM, waits for a mask/value trigger, writes post_count further
// samples and then pulses done_acq back to the dispatcher.
// Optional feature macro: ACQ_EDGE_TRIG_EN (adds trig_edge edge qualifier).
module acq_capture_ctrl #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_W     = 10,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  grant_acq,
    output logic                  done_acq,
    input  logic [CHANNELS-1:0]   probe,
    input  logic [CHANNELS-1:0]   trig_mask,
    input  logic [CHANNELS-1:0]   trig_value,
`ifdef ACQ_EDGE_TRIG_EN
    input  logic [CHANNELS-1:0]   trig_edge,
`endif
    input  logic [ADDR_W-1:0]     post_count,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [CHANNELS-1:0]   mem_wdata,
    output logic [ADDR_W-1:0]     trig_addr,
    output logic                  capturing,
    output logic                  triggered
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_POST,
        S_DONE,
        S_REL
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [CHANNELS-1:0]   r_sync1;
    logic [CHANNELS-1:0]   r_smp;

    logic [CHANNELS-1:0]   r_mask;
    logic [CHANNELS-1:0]   r_value;
    logic [ADDR_W-1:0]     r_post_cfg;
    logic [PRESCALE_W-1:0] r_prescale;

    logic [ADDR_W-1:0]     r_wptr;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [ADDR_W-1:0]     r_post;

    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [CHANNELS-1:0]   r_mem_wdata;
    logic [ADDR_W-1:0]     r_trig_addr;
    logic                  r_triggered;
    logic                  r_done;
    logic                  r_capturing;

    logic                  w_start;
    logic                  w_active;
    logic                  w_strobe;
    logic                  w_level_hit;
    logic                  w_trig;
    logic                  w_write;
    logic                  w_fire;

    // Strobe counter sits at zero on the first ARM cycle, so the first strobe is immediate
    assign w_start     = (r_state == S_IDLE) && grant_acq;
    assign w_active    = ((r_state == S_ARM) || (r_state == S_POST)) && grant_acq;
    assign w_strobe    = (r_pcnt == '0);
    assign w_level_hit = (((r_smp ^ r_value) & r_mask) == '0);

`ifdef ACQ_EDGE_TRIG_EN
    logic [CHANNELS-1:0]   r_edge;
    logic [CHANNELS-1:0]   r_prev;
    logic                  r_prev_vld;
    logic                  w_edge_hit;

    // Edge qualifier needs a previous strobed sample; none exists on the first strobe
    assign w_edge_hit = r_prev_vld && (((r_smp ^ r_prev) & r_edge) != '0);
    assign w_trig     = w_level_hit && ((r_edge == '0) || w_edge_hit);

    // Track the last strobed sample and the edge configuration for this run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge     <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
        end else begin
            if (w_start) begin
                r_edge     <= trig_edge;
                r_prev_vld <= 1'b0;
            end else if (w_write) begin
                r_prev     <= r_smp;
                r_prev_vld <= 1'b1;
            end
        end
    end
`else
    assign w_trig = w_level_hit;
`endif

    // Two-flop synchroniser for the asynchronous probe pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_smp   <= '0;
        end else begin
            r_sync1 <= probe;
            r_smp   <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and per-cycle write/trigger decisions; a dropped grant overrides everything
    always_comb begin
        w_next  = r_state;
        w_write = 1'b0;
        w_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (grant_acq) begin
                    w_next = S_ARM;
                end
            end
            S_ARM: begin
                if (!grant_acq) begin
                    w_next = S_IDLE;
                end else if (w_strobe) begin
                    w_write = 1'b1;
                    if (w_trig) begin
                        w_fire = 1'b1;
                        w_next = S_POST;
                    end
                end
            end
            S_POST: begin
                if (!grant_acq) begin
                    w_next = S_IDLE;
                end else if (r_post == '0) begin
                    w_next = S_DONE;
                end else if (w_strobe) begin
                    w_write = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_REL;
            end
            S_REL: begin
                if (!grant_acq) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Run configuration, pointers, prescale and post counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask     <= '0;
            r_value    <= '0;
            r_post_cfg <= '0;
            r_prescale <= '0;
            r_wptr     <= '0;
            r_pcnt     <= '0;
            r_post     <= '0;
        end else begin
            if (w_start) begin
                r_mask     <= trig_mask;
                r_value    <= trig_value;
                r_post_cfg <= post_count;
                r_prescale <= prescale;
                r_wptr     <= '0;
                r_pcnt     <= '0;
            end else if (w_active) begin
                r_pcnt <= (r_pcnt >= r_prescale) ? '0 : r_pcnt + 1'b1;
            end
            if (w_write) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_fire) begin
                r_post <= r_post_cfg;
            end else if (w_write && (r_state == S_POST)) begin
                r_post <= r_post - 1'b1;
            end
        end
    end

    // Registered RAM write port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_trig_addr <= '0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_capturing <= 1'b0;
        end else begin
            r_mem_we <= w_write;
            if (w_write) begin
                r_mem_addr  <= r_wptr;
                r_mem_wdata <= r_smp;
            end
            if (w_start) begin
                r_triggered <= 1'b0;
            end else if (w_fire) begin
                r_triggered <= 1'b1;
                r_trig_addr <= r_wptr;
            end
            r_done      <= (w_next == S_DONE);
            r_capturing <= (w_next == S_ARM) || (w_next == S_POST);
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign trig_addr = r_trig_addr;
    assign triggered = r_triggered;
    assign done_acq  = r_done;
    assign capturing = r_capturing;

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// tb_acq_capture_ctrl: directed bench for acq_capture_ctrl.
// A per-cycle vector table covers the basic acquisition and handshake; short
// hand-written sequences cover prescaling, wrap-around, aborts and reset.
module tb_acq_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        grant_acq;
    logic        grant4;
    logic [7:0]  probe;
    logic [7:0]  trig_mask;
    logic [7:0]  trig_value;
    logic [7:0]  trig_edge;
    logic [9:0]  post_count;
    logic [3:0]  post4;
    logic [15:0] prescale;

    logic        done_acq, mem_we, capturing, triggered;
    logic [9:0]  mem_addr, trig_addr;
    logic [7:0]  mem_wdata;

    logic        done4, we4, capt4, trig4;
    logic [3:0]  addr4, taddr4;
    logic [7:0]  wdata4;

    logic        sel;
    logic        m_we, m_done;
    logic [9:0]  m_addr, m_taddr;
    logic [7:0]  m_wdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int nw, done_cyc;
    int wa [64];
    int wd [64];
    int wc [64];

    always #5 clk = ~clk;

    acq_capture_ctrl #(.CHANNELS(8), .ADDR_W(10), .PRESCALE_W(16)) u_dut (
        .clk(clk), .rst(rst), .grant_acq(grant_acq), .done_acq(done_acq),
        .probe(probe), .trig_mask(trig_mask), .trig_value(trig_value),
`ifdef ACQ_EDGE_TRIG_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post_count), .prescale(prescale),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .trig_addr(trig_addr), .capturing(capturing), .triggered(triggered)
    );

    acq_capture_ctrl #(.CHANNELS(8), .ADDR_W(4), .PRESCALE_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .grant_acq(grant4), .done_acq(done4),
        .probe(probe), .trig_mask(trig_mask), .trig_value(trig_value),
`ifdef ACQ_EDGE_TRIG_EN
        .trig_edge(trig_edge),
`endif
        .post_count(post4), .prescale(prescale),
        .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
        .trig_addr(taddr4), .capturing(capt4), .triggered(trig4)
    );

    assign m_we    = sel ? we4 : mem_we;
    assign m_done  = sel ? done4 : done_acq;
    assign m_addr  = sel ? {6'd0, addr4} : mem_addr;
    assign m_taddr = sel ? {6'd0, taddr4} : trig_addr;
    assign m_wdata = sel ? wdata4 : mem_wdata;

    typedef struct {
        logic       grant;
        logic       we;
        logic [9:0] addr;
        logic       done;
        logic       capt;
        logic       trig;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_grant();
        grant_acq = 1'b0;
        grant4    = 1'b0;
        repeat (3) step();
    endtask

    // Run one acquisition on the selected instance, logging writes until done_acq
    task automatic capture(input int raise_after, input logic [7:0] raise_val, input int max_cyc);
        int cyc;
        nw = 0;
        done_cyc = -1;
        cyc = 0;
        while (cyc < max_cyc && done_cyc < 0) begin
            step();
            cyc++;
            if (m_we) begin
                if (nw < 64) begin
                    wa[nw] = int'(m_addr);
                    wd[nw] = int'(m_wdata);
                    wc[nw] = cyc;
                end
                nw++;
                if (nw == raise_after) probe = raise_val;
            end
            if (m_done) done_cyc = cyc;
        end
        chk("done_seen", (done_cyc >= 0), 1);
        step();
        chk("done_one_cycle", m_done, 0);
    endtask

    initial begin
        // Test 1: prescale 0, no mask, post_count 3
        tbl[0]  = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 10'd0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 10'd1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 10'd2, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 10'd3, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0};

        sel = 1'b0;
        rst = 1'b1;
        grant_acq = 1'b0;
        grant4 = 1'b0;
        probe = 8'hA5;
        trig_mask = 8'h00;
        trig_value = 8'h00;
        trig_edge = 8'h00;
        post_count = 10'd3;
        post4 = 4'd0;
        prescale = 16'd0;

        #2;
        chk("rst_we", mem_we, 0);
        chk("rst_capt", capturing, 0);
        chk("rst_done", done_acq, 0);
        chk("rst_trig", triggered, 0);
        chk("rst_addr", mem_addr, 0);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("idle_capt", capturing, 0);

        for (int i = 0; i < 13; i++) begin
            grant_acq = tbl[i].grant;
            step();
            chk($sformatf("t1_we[%0d]", i), mem_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("t1_addr[%0d]", i), mem_addr, tbl[i].addr);
                chk($sformatf("t1_data[%0d]", i), mem_wdata, 8'hA5);
            end
            chk($sformatf("t1_done[%0d]", i), done_acq, tbl[i].done);
            chk($sformatf("t1_capt[%0d]", i), capturing, tbl[i].capt);
            chk($sformatf("t1_trig[%0d]", i), triggered, tbl[i].trig);
            if (i == 1) chk("t1_trig_addr", trig_addr, 0);
        end

        // post_count 0: single trigger write, then done
        post_count = 10'd0;
        grant_acq = 1'b1;
        capture(-1, 8'h00, 50);
        chk("p0_writes", nw, 1);
        chk("p0_addr", wa[0], 0);
        chk("p0_done_gap", done_cyc - wc[0], 1);
        release_grant();

        // Test 2: prescale 4, bit0 level trigger after 7 strobes
        probe = 8'h00;
        trig_mask = 8'h01;
        trig_value = 8'h01;
        post_count = 10'd2;
        prescale = 16'd4;
        repeat (3) step();
        grant_acq = 1'b1;
        capture(7, 8'h01, 200);
        chk("t2_writes", nw, 10);
        chk("t2_trig_addr", trig_addr, 7);
        chk("t2_done_gap", done_cyc - wc[9], 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t2_addr[%0d]", i), wa[i], i);
            chk($sformatf("t2_data[%0d]", i), wd[i], (i >= 7) ? 1 : 0);
            if (i > 0) chk($sformatf("t2_spacing[%0d]", i), wc[i] - wc[i-1], 5);
        end
        release_grant();

        // Test 3: 16-deep RAM, trigger at the 20th strobe wraps to address 3
        sel = 1'b1;
        probe = 8'h00;
        prescale = 16'd3;
        post4 = 4'd2;
        repeat (3) step();
        grant4 = 1'b1;
        capture(19, 8'h01, 300);
        chk("t3_writes", nw, 22);
        chk("t3_trig_addr", m_taddr, 3);
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("t3_addr[%0d]", i), wa[i], i % 16);
            chk($sformatf("t3_data[%0d]", i), wd[i], (i >= 19) ? 1 : 0);
        end
        release_grant();
        sel = 1'b0;

        // Test 4: grant dropped in POST aborts without done; re-grant restarts
        probe = 8'h3C;
        trig_mask = 8'h00;
        post_count = 10'd20;
        prescale = 16'd0;
        grant_acq = 1'b1;
        repeat (4) step();
        chk("t4_in_post_we", mem_we, 1);
        grant_acq = 1'b0;
        step();
        chk("t4_abort_capt", capturing, 0);
        chk("t4_abort_we", mem_we, 0);
        chk("t4_abort_trig_kept", triggered, 1);
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (done_acq || mem_we) seen_done = 1;
            end
            chk("t4_no_done_after_abort", seen_done, 0);
        end
        grant_acq = 1'b1;
        step();
        chk("t4_regrant_capt", capturing, 1);
        chk("t4_regrant_trig_clr", triggered, 0);
        step();
        chk("t4_regrant_we", mem_we, 1);
        chk("t4_regrant_addr", mem_addr, 0);
        release_grant();

        // Test 5: asynchronous reset mid-ARM while writing
        probe = 8'h55;
        trig_mask = 8'hFF;
        trig_value = 8'h00;
        repeat (3) step();
        grant_acq = 1'b1;
        repeat (4) step();
        chk("t5_pre_we", mem_we, 1);
        chk("t5_pre_capt", capturing, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_capt", capturing, 0);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_wdata", mem_wdata, 0);
        chk("t5_rst_done", done_acq, 0);
        step();
        grant_acq = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("t5_idle_capt", capturing, 0);
        end
        grant_acq = 1'b1;
        step();
        chk("t5_rearm_capt", capturing, 1);
        release_grant();

`ifdef ACQ_EDGE_TRIG_EN
        // Test 6: edge qualifier on bit1
        trig_mask = 8'h00;
        trig_edge = 8'h02;
        post_count = 10'd0;
        prescale = 16'd3;
        probe = 8'h02;
        repeat (3) step();
        grant_acq = 1'b1;
        repeat (30) step();
        chk("t6_held_no_trig", triggered, 0);
        chk("t6_held_capt", capturing, 1);
        release_grant();
        probe = 8'h00;
        repeat (3) step();
        grant_acq = 1'b1;
        capture(3, 8'h02, 200);
        chk("t6_writes", nw, 4);
        chk("t6_trig_addr", trig_addr, 3);
        release_grant();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
